frame_port_b_reader: RTL and testbench
======================================

# frame_port_b_reader

Streaming reader for the memory stage's read-only port B (`address_b` / `read_data_b`). On a start pulse it walks a WIDTH×HEIGHT frame from a base address in the unified 18-bit address map: image ROM at 0..89999, RAM from 90300 up, and the 90000..90299 window that reads as zero. It absorbs the fixed port-B read latency and emits pixels on a valid/ready stream toward the display/output path. Throughput is one pixel per clock under no backpressure.

## Interface
- `WIDTH`, default 300: pixels per line.
- `HEIGHT`, default 300: lines per frame.
- `READ_LATENCY`, default 2: clocks from `address_b` presented to `read_data_b` valid. Port B registers both its input and its output.
- `FIFO_DEPTH`, default 4: output buffer entries. Power of two, ≥ READ_LATENCY+1.
- `clk` in 1: single clock, same clock as memory port B.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a frame.
- `frame_base` in 18: first address of the frame, sampled on an accepted `start`.
- `address_b` out 18: to the memory stage's `address_b`.
- `read_data_b` in 24: from the memory stage's `read_data_b`.
- `pixel_data` out 24: head of the output FIFO.
- `pixel_valid` out 1: FIFO not empty.
- `pixel_ready` in 1: consumer accepts when valid and ready are both high.
- `pixel_eol` out 1: the head pixel is the last pixel of a line.
- `pixel_eof` out 1: the head pixel is the last pixel of the frame.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse.
- `checksum` out 24: present only with `FRAME_READER_CHECKSUM_EN`.

## Operation
- **FSM states: IDLE, FETCH, DRAIN.**
  - IDLE → FETCH on `start`. On entry: base latched, x=0, y=0, `busy`=1.
  - FETCH issues one read per cycle while credits allow. After issuing (x=WIDTH-1, y=HEIGHT-1) it goes to DRAIN.
  - DRAIN waits until the in-flight count is 0, the FIFO is empty, and the last pixel has been accepted. It then returns to IDLE, pulses `frame_done`, and drops `busy`.
- **`start` while busy:** ignored.
- **Credit rule:**
  - A read issues only when fifo_count + inflight + 1 ≤ FIFO_DEPTH.
  - A pop in the same cycle does not count toward this. The rule is deliberately conservative and registered-path friendly.
  - Overflow must be impossible.
- **In-flight tracking:**
  - An issued read pushes a 1 into a READ_LATENCY-deep valid shift register, carrying eol/eof tag bits alongside.
  - When the register's output bit is 1, `read_data_b` plus its tags are written to the FIFO.
- **Address generation:**
  - `address_b` = base + y×WIDTH + x, kept as a running 18-bit offset register with no multiplier.
  - Arithmetic wraps modulo 2^18.
  - `address_b` holds its last value when no read issues. It resets to 0.
- **Counters:** x wraps at WIDTH-1 and y increments. The tags are eol = (x==WIDTH-1) and eof = eol && (y==HEIGHT-1).
- **Reset** (asynchronous, any state including mid-frame):
  - Takes effect immediately: FSM to IDLE, FIFO and shift register cleared.
  - In-flight returning data is discarded. No `frame_done`.
- **Outputs after reset:**
  - `address_b`, `pixel_data`, `checksum` = 0.
  - `pixel_valid`, `pixel_eol`, `pixel_eof`, `busy`, `frame_done` = 0.

## Timing
- Let `start` be sampled at edge k.
  - The first `address_b`=base is driven after edge k+1.
  - Data is written to the FIFO at edge k+1+READ_LATENCY.
  - `pixel_valid` first goes high after edge k+1+READ_LATENCY, which is 3 cycles for the default.
- **No backpressure:** one pixel per cycle sustained. A 300×300 frame completes with the `frame_done` pulse 90000+READ_LATENCY+1 cycles after k.
- **Backpressure:** reads stall within one cycle of the credits being exhausted. No data is lost. `pixel_data` is stable while valid && !ready.
- **Push and pop in the same cycle:** both take effect and the count is unchanged.
- `frame_done` is asserted in the cycle after the eof pixel handshake.
- **Back-to-back frames:** `start` is accepted in the same cycle that `frame_done` is high.

## Configuration
- **`FRAME_READER_CHECKSUM_EN` defined:**
  - `checksum` is a 24-bit mod-2^24 sum of every accepted pixel in the current frame.
  - It clears on an accepted `start`.
  - It is final and stable from the `frame_done` cycle until the next `start`.
- **Not defined:** the port and its adder are absent. There are no other behavioural differences.

## Test plan
- **Basic frame:** reset, then `start` with frame_base=0, WIDTH=4, HEIGHT=2, `pixel_ready`=1, memory model returning data=address with 2-cycle latency.
  - Pixels 0..7 in order, one per cycle, first valid 3 cycles after start.
  - eol on 3 and 7, eof on 7. `frame_done` one cycle after pixel 7.
- **RAM base:** frame_base=90300 → `address_b` sequence 90300..90307. Data matches the model.
- **Backpressure:** `pixel_ready` toggling 1,0,0,1 repeatedly.
  - Never more than FIFO_DEPTH entries outstanding.
  - Data held stable while stalled.
  - Same 8-pixel sequence with no drops or duplicates.
- **Mid-frame events:**
  - `start` pulsed during FETCH → ignored, base unchanged.
  - `rst` asserted mid-FETCH → all outputs 0 immediately. A subsequent frame is correct and no stale pixel appears.
- **Checksum** (with macro): frame of 8 pixels with values 0..7 → `checksum`=28 at `frame_done`. Second frame with values 0xFFFFFF ×2 → 0xFFFFFE, wrapping.
- **Back-to-back:** `start` in the `frame_done` cycle → the second frame begins without an idle gap and both frames are complete.

Source files
------------

// File: rtl/frame_port_b_reader_if.sv
// Bundle between the port-B frame reader, the memory stage and the display sink.
// checksum is present only when FRAME_READER_CHECKSUM_EN is defined.
interface frame_port_b_reader_if;
    logic        start;
    logic [17:0] frame_base;
    logic [17:0] address_b;
    logic [23:0] read_data_b;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        pixel_eol;
    logic        pixel_eof;
    logic        busy;
    logic        frame_done;
`ifdef FRAME_READER_CHECKSUM_EN
    logic [23:0] checksum;

    modport master (
        input  start, frame_base, read_data_b, pixel_ready,
        output address_b, pixel_data, pixel_valid, pixel_eol, pixel_eof,
               busy, frame_done, checksum
    );
    modport slave (
        output start, frame_base, read_data_b, pixel_ready,
        input  address_b, pixel_data, pixel_valid, pixel_eol, pixel_eof,
               busy, frame_done, checksum
    );
`else
    modport master (
        input  start, frame_base, read_data_b, pixel_ready,
        output address_b, pixel_data, pixel_valid, pixel_eol, pixel_eof,
               busy, frame_done
    );
    modport slave (
        output start, frame_base, read_data_b, pixel_ready,
        input  address_b, pixel_data, pixel_valid, pixel_eol, pixel_eof,
               busy, frame_done
    );
`endif
endinterface

// File: rtl/frame_port_b_reader.sv
// Streams a WIDTH x HEIGHT frame from memory port B into a credit-limited output FIFO.
// Optional running pixel checksum: define FRAME_READER_CHECKSUM_EN.
module frame_port_b_reader #(
    parameter int WIDTH        = 300,
    parameter int HEIGHT       = 300,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_port_b_reader_if.master bus
);
    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    typedef struct packed {
        logic        eol;
        logic        eof;
        logic [23:0] data;
    } entry_t;

    state_t                  state, next_state;
    logic [17:0]             base, offset, addr_q;
    logic [XW-1:0]           x;
    logic [YW-1:0]           y;
    logic [READ_LATENCY-1:0] vld_pipe, eol_pipe, eof_pipe;
    entry_t                  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           fifo_count;
    logic                    start_ok, issue, credit_ok, busy_c, done_q;
    logic                    last_x, last_y, push, pop, valid_c, eof_pop;
    int                      inflight;

    assign start_ok = (state == IDLE) && bus.start;
    assign last_x   = (x == XW'(WIDTH - 1));
    assign last_y   = (y == YW'(HEIGHT - 1));
    assign push     = vld_pipe[READ_LATENCY-1];
    assign valid_c  = (fifo_count != '0);
    assign pop      = valid_c && bus.pixel_ready;
    assign eof_pop  = pop && fifo_mem[rd_ptr].eof;

    // Credits ignore a same-cycle pop so the issue decision depends only on registers.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < READ_LATENCY; i++) inflight += int'(vld_pipe[i]);
        credit_ok = (int'(fifo_count) + inflight + 1) <= FIFO_DEPTH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = FETCH;
            FETCH:   if (issue && last_x && last_y) next_state = DRAIN;
            DRAIN:   if (eof_pop) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        issue  = 1'b0;
        busy_c = 1'b0;
        case (state)
            FETCH: begin
                busy_c = 1'b1;
                issue  = credit_ok;
            end
            DRAIN:   busy_c = 1'b1;
            default: ;
        endcase
    end

    // Row-major walk makes y*WIDTH+x a plain issue count, so no multiplier is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base   <= '0;
            offset <= '0;
            addr_q <= '0;
            x      <= '0;
            y      <= '0;
        end else if (start_ok) begin
            base   <= bus.frame_base;
            offset <= '0;
            x      <= '0;
            y      <= '0;
        end else if (issue) begin
            addr_q <= base + offset;
            offset <= offset + 18'd1;
            if (last_x) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            eol_pipe <= '0;
            eof_pipe <= '0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | READ_LATENCY'(issue);
            eol_pipe <= (eol_pipe << 1) | READ_LATENCY'(last_x);
            eof_pipe <= (eof_pipe << 1) | READ_LATENCY'(last_x && last_y);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{eol: eol_pipe[READ_LATENCY-1],
                                      eof: eof_pipe[READ_LATENCY-1],
                                      data: bus.read_data_b};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= (state == DRAIN) && eof_pop;
    end

`ifdef FRAME_READER_CHECKSUM_EN
    logic [23:0] sum_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           sum_q <= '0;
        else if (start_ok) sum_q <= '0;
        else if (pop)      sum_q <= sum_q + fifo_mem[rd_ptr].data;
    end
    assign bus.checksum = sum_q;
`endif

    assign bus.address_b   = addr_q;
    assign bus.pixel_data  = fifo_mem[rd_ptr].data;
    assign bus.pixel_valid = valid_c;
    assign bus.pixel_eol   = valid_c && fifo_mem[rd_ptr].eol;
    assign bus.pixel_eof   = valid_c && fifo_mem[rd_ptr].eof;
    assign bus.busy        = busy_c;
    assign bus.frame_done  = done_q;
endmodule

// File: tb/tb_frame_port_b_reader.sv
// Randomized self-checking bench for frame_port_b_reader against a frame-level reference model.
// Exercises the checksum only when FRAME_READER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_frame_port_b_reader;
    localparam int W = 4, H = 2, RL = 2, DEPTH = 4, NPIX = W * H;

    typedef struct packed {
        logic        eol;
        logic        eof;
        logic [23:0] data;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    frame_port_b_reader_if bus();

    frame_port_b_reader #(.WIDTH(W), .HEIGHT(H), .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH))
        dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, cyc = 0;
    int mem_mode = 0, ready_mode = 0, rphase = 0;
    logic [23:0] mem_key = '0;
    logic [17:0] mem_base = '0;

    // Memory map: zero window at 90000..90299, otherwise a pattern picked per test.
    function automatic logic [23:0] mem_read(input logic [17:0] a);
        if (a >= 18'd90000 && a <= 18'd90299) return 24'd0;
        case (mem_mode)
            1:       return {6'd0, a} ^ mem_key;
            2:       return (a == mem_base || a == mem_base + 18'd1) ? 24'hFFFFFF : 24'd0;
            default: return {6'd0, a};
        endcase
    endfunction

    // Port B: data for the address driven after an issue edge is presented RL edges after it.
    always @(posedge clk) bus.read_data_b <= mem_read(bus.address_b);
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: begin
                bus.pixel_ready = (rphase == 0) || (rphase == 3);
                rphase = (rphase + 1) % 4;
            end
            2:       bus.pixel_ready = 1'($urandom_range(0, 1));
            default: bus.pixel_ready = 1'b1;
        endcase
    end

    pix_t got_q[$], exp_q[$];
    logic [17:0] addr_q[$];
    logic [17:0] prev_addr = '0;
    logic [23:0] stall_data = '0, done_sum = '0;
    int issued, accepted, max_out, first_valid_cyc, done_cnt, done_cyc, last_acc_cyc, stall_err;
    int k_cyc;
    bit stalled, busy_after_start, busy_at_done;

    always @(negedge clk) begin
        if (rst) begin
            prev_addr = '0;
            stalled   = 1'b0;
        end else begin
            if (bus.address_b !== prev_addr) begin
                issued++;
                addr_q.push_back(bus.address_b);
            end
            prev_addr = bus.address_b;
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (bus.pixel_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stalled && bus.pixel_data !== stall_data) stall_err++;
            stalled    = bus.pixel_valid && !bus.pixel_ready;
            stall_data = bus.pixel_data;
            if (bus.pixel_valid && bus.pixel_ready) begin
                got_q.push_back({bus.pixel_eol, bus.pixel_eof, bus.pixel_data});
                accepted++;
                last_acc_cyc = cyc;
            end
            if (bus.frame_done) begin
                done_cnt++;
                done_cyc = cyc;
`ifdef FRAME_READER_CHECKSUM_EN
                done_sum = bus.checksum;
`endif
            end
        end
    end

    function automatic void mon_clear();
        got_q.delete();
        addr_q.delete();
        issued = 0; accepted = 0; max_out = 0; stall_err = 0;
        first_valid_cyc = -1; done_cnt = 0; done_cyc = -1; last_acc_cyc = -1;
    endfunction

    // Reference frame: addresses base+i mod 2^18 in row-major order, tags from i.
    function automatic void build_exp(input logic [17:0] base);
        pix_t p;
        for (int i = 0; i < NPIX; i++) begin
            p.eol  = (i % W) == (W - 1);
            p.eof  = (i == NPIX - 1);
            p.data = mem_read(base + 18'(i));
            exp_q.push_back(p);
        end
    endfunction

    function automatic logic [23:0] exp_sum();
        logic [23:0] s = '0;
        foreach (exp_q[i]) s = s + exp_q[i].data;
        return s;
    endfunction

    task automatic run_frame(input logic [17:0] base, input int restart_at, output bit to);
        mon_clear();
        exp_q.delete();
        mem_base = base;
        build_exp(base);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.frame_base = base;
        @(posedge clk); #1;
        k_cyc = cyc; bus.start = 1'b0; bus.frame_base = 18'($urandom);
        @(negedge clk);
        busy_after_start = bus.busy;
        to = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (bus.frame_done) begin
                to = 1'b0;
                busy_at_done = bus.busy;
                break;
            end
            if (i == restart_at) begin
                bus.start = 1'b1; bus.frame_base = base ^ 18'h155;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({bus.address_b, bus.pixel_data, bus.pixel_valid, bus.pixel_eol, bus.pixel_eof,
             bus.busy, bus.frame_done} !== '0) begin
            n_err++; $display("FAIL reset_outputs got addr=%0h data=%0h v=%b busy=%b exp all 0",
                              bus.address_b, bus.pixel_data, bus.pixel_valid, bus.busy);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.pixel_valid, bus.busy, bus.frame_done, bus.address_b} !== '0) begin
            n_err++; $display("FAIL idle_after_reset got v=%b busy=%b done=%b exp 0",
                              bus.pixel_valid, bus.busy, bus.frame_done);
        end
    endtask

    task automatic test_basic_frame();
        bit to;
        mem_mode = 0; ready_mode = 0;
        run_frame(18'd0, -1, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL basic_timeout got timeout exp frame_done"); end
        n_cmp++; if (busy_after_start !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b exp 1", busy_after_start); end
        n_cmp++; if (first_valid_cyc - k_cyc != RL + 1) begin
            n_err++; $display("FAIL basic_first_valid got %0d exp %0d", first_valid_cyc - k_cyc, RL + 1); end
        n_cmp++; if (got_q.size() != NPIX) begin n_err++; $display("FAIL basic_count got %0d exp %0d", got_q.size(), NPIX); end
        for (int i = 0; i < NPIX && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL basic_pix[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (done_cyc - k_cyc != NPIX + RL + 1) begin
            n_err++; $display("FAIL basic_done_latency got %0d exp %0d", done_cyc - k_cyc, NPIX + RL + 1); end
        n_cmp++; if (done_cyc != last_acc_cyc + 1) begin
            n_err++; $display("FAIL basic_done_after_eof got %0d exp %0d", done_cyc, last_acc_cyc + 1); end
        n_cmp++; if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL basic_busy_drop got %b exp 0", busy_at_done); end
        repeat (4) @(negedge clk);
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL basic_done_pulse got %0d exp 1", done_cnt); end
    endtask

    task automatic test_ram_base();
        bit to;
        mem_mode = 0; ready_mode = 0;
        run_frame(18'd90300, -1, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL ram_timeout got timeout exp frame_done"); end
        n_cmp++; if (addr_q.size() != NPIX) begin n_err++; $display("FAIL ram_addr_count got %0d exp %0d", addr_q.size(), NPIX); end
        for (int i = 0; i < NPIX && i < addr_q.size(); i++) begin
            n_cmp++; if (addr_q[i] !== 18'(90300 + i)) begin
                n_err++; $display("FAIL ram_addr[%0d] got %0d exp %0d", i, addr_q[i], 90300 + i); end
        end
        n_cmp++; if (got_q != exp_q) begin n_err++; $display("FAIL ram_pixels got %0d pixels exp %0d matching", got_q.size(), exp_q.size()); end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [17:0] b;
        mem_mode = 1; mem_key = 24'($urandom); ready_mode = 1; rphase = 0;
        for (int r = 0; r < 2; r++) begin
            b = 18'(100000 + $urandom_range(0, 100000));
            if (b == bus.address_b) b = b + 18'd1;
            run_frame(b, -1, to);
            n_cmp++; if (to) begin n_err++; $display("FAIL bp_timeout got timeout exp frame_done"); end
            n_cmp++; if (got_q != exp_q) begin n_err++; $display("FAIL bp_pixels got %0d pixels exp %0d matching", got_q.size(), exp_q.size()); end
            n_cmp++; if (max_out > DEPTH) begin n_err++; $display("FAIL bp_outstanding got %0d exp <= %0d", max_out, DEPTH); end
            n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL bp_stall_stable got %0d changes exp 0", stall_err); end
        end
    endtask

    task automatic test_random_frames();
        bit to;
        logic [17:0] b;
        logic [17:0] bases [4];
        bases = '{18'd89996, 18'd90296, 18'd262140, 18'd0};
        bases[3] = 18'($urandom);
        mem_mode = 1; ready_mode = 2;
        for (int r = 0; r < 4; r++) begin
            mem_key = 24'($urandom);
            b = bases[r];
            if (b == bus.address_b) b = b + 18'd1;
            run_frame(b, -1, to);
            n_cmp++; if (to) begin n_err++; $display("FAIL rand_timeout[%0d] got timeout exp frame_done", r); end
            n_cmp++; if (got_q != exp_q) begin n_err++; $display("FAIL rand_pixels[%0d] base %0d got %0d pixels exp %0d matching", r, b, got_q.size(), exp_q.size()); end
            n_cmp++; if (max_out > DEPTH) begin n_err++; $display("FAIL rand_outstanding got %0d exp <= %0d", max_out, DEPTH); end
            n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL rand_stall_stable got %0d exp 0", stall_err); end
        end
    endtask

    task automatic test_mid_frame_start();
        bit to;
        mem_mode = 0; ready_mode = 0;
        run_frame(18'd5000, 2, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL midstart_timeout got timeout exp frame_done"); end
        n_cmp++; if (got_q != exp_q) begin n_err++; $display("FAIL midstart_pixels got %0d pixels exp %0d from original base", got_q.size(), exp_q.size()); end
        repeat (6) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0 || done_cnt != 1) begin
            n_err++; $display("FAIL midstart_idle got busy=%b done=%0d exp 0/1", bus.busy, done_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        mem_mode = 1; mem_key = 24'hA5A5A5; ready_mode = 1; rphase = 0;
        mon_clear();
        @(posedge clk); #1 bus.start = 1'b1; bus.frame_base = 18'd120000;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.address_b, bus.pixel_data, bus.pixel_valid, bus.pixel_eol, bus.pixel_eof,
             bus.busy, bus.frame_done} !== '0) begin
            n_err++; $display("FAIL rst_mid_outputs got addr=%0h data=%0h v=%b busy=%b exp all 0",
                              bus.address_b, bus.pixel_data, bus.pixel_valid, bus.busy);
        end
`ifdef FRAME_READER_CHECKSUM_EN
        n_cmp++; if (bus.checksum !== 24'd0) begin n_err++; $display("FAIL rst_mid_checksum got %0h exp 0", bus.checksum); end
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ready_mode = 0;
        run_frame(18'(1 + $urandom_range(0, 80000)), -1, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL rst_mid_timeout got timeout exp frame_done"); end
        n_cmp++; if (got_q != exp_q) begin n_err++; $display("FAIL rst_mid_pixels got %0d pixels exp %0d clean", got_q.size(), exp_q.size()); end
        n_cmp++; if (done_cyc - k_cyc != NPIX + RL + 1) begin
            n_err++; $display("FAIL rst_mid_latency got %0d exp %0d", done_cyc - k_cyc, NPIX + RL + 1); end
    endtask

`ifdef FRAME_READER_CHECKSUM_EN
    task automatic test_checksum();
        bit to;
        mem_mode = 0; ready_mode = 0;
        run_frame(18'd0, -1, to);
        n_cmp++; if (done_sum !== 24'd28) begin n_err++; $display("FAIL csum_0_7 got %0d exp 28", done_sum); end
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.checksum !== 24'd28) begin n_err++; $display("FAIL csum_stable got %0d exp 28", bus.checksum); end
        mem_mode = 2; ready_mode = 2;
        run_frame(18'(90400 + $urandom_range(0, 5000)), -1, to);
        n_cmp++; if (done_sum !== 24'hFFFFFE) begin n_err++; $display("FAIL csum_wrap got %h exp fffffe", done_sum); end
        n_cmp++; if (done_sum !== exp_sum()) begin n_err++; $display("FAIL csum_model got %h exp %h", done_sum, exp_sum()); end
    endtask
`endif

    task automatic test_back_to_back();
        bit to1, to2;
        int k2, d2;
        logic [17:0] b1, b2;
        mem_mode = 1; mem_key = 24'($urandom); ready_mode = 0;
        b1 = 18'(140000 + $urandom_range(0, 1000));
        b2 = b1 + 18'd100;
        mon_clear();
        exp_q.delete();
        build_exp(b1);
        build_exp(b2);
        @(posedge clk); #1 bus.start = 1'b1; bus.frame_base = b1;
        @(posedge clk); #1 bus.start = 1'b0;
        to1 = 1'b1; k2 = 0; d2 = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.frame_done) begin
                bus.start = 1'b1; bus.frame_base = b2; k2 = cyc + 1; to1 = 1'b0;
                break;
            end
        end
        @(posedge clk); #1 bus.start = 1'b0;
        to2 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.frame_done) begin d2 = cyc; to2 = 1'b0; break; end
        end
        #1;
        n_cmp++; if (to1 || to2) begin n_err++; $display("FAIL b2b_timeout got to1=%b to2=%b exp 0/0", to1, to2); end
        n_cmp++; if (got_q != exp_q) begin n_err++; $display("FAIL b2b_pixels got %0d pixels exp %0d matching", got_q.size(), exp_q.size()); end
        n_cmp++; if (done_cnt != 2) begin n_err++; $display("FAIL b2b_done_count got %0d exp 2", done_cnt); end
        n_cmp++; if (d2 - k2 != NPIX + RL + 1) begin n_err++; $display("FAIL b2b_no_gap got %0d exp %0d", d2 - k2, NPIX + RL + 1); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.frame_base = '0;
        bus.pixel_ready = 1'b1;
        mon_clear();
        test_reset();
        test_basic_frame();
        test_ram_base();
        test_backpressure();
        test_random_frames();
        test_mid_frame_start();
        test_reset_mid_frame();
`ifdef FRAME_READER_CHECKSUM_EN
        test_checksum();
`endif
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
